// File: rtl/dcache_store_buffer.sv
// Four-entry store buffer between writeback and the dcache write port.
// Each store drains as one or two dword-aligned, byte-enabled requests.
module dcache_store_buffer (
    input  logic        CLK,
    input  logic        RST,
    input  logic        WB_V_DCACHE_WRITE,
    input  logic [1:0]  WB_DATASIZE,
    input  logic [31:0] WB_DCACHE_DATA,
    input  logic [31:0] WB_DCACHE_ADDRESS,
    input  logic        LD_V,
    input  logic [31:0] LD_ADDRESS,
    input  logic        DC_WR_ACK,
    output logic        DC_WR_REQ,
    output logic [31:0] DC_WR_ADDR,
    output logic [31:0] DC_WR_DATA,
    output logic [3:0]  DC_WR_BE,
    output logic        Out_full,
    output logic        Out_empty,
    output logic        Out_ld_conflict,
    output logic        Out_overflow
);
    typedef enum logic [1:0] {IDLE, REQ_LO, REQ_HI} state_t;

    state_t      state_q, state_d;
    logic [1:0]  head_q, tail_q;
    logic [2:0]  count_q, count_d;
    logic [3:0]  valid_q;
    logic        ovf_q;
    logic [31:0] addr_q [4];
    logic [31:0] data_q [4];
    logic [1:0]  size_q [4];

    logic        push, drop, pop;
    logic [31:0] h_addr, h_data, h_base;
    logic [1:0]  h_size;
    logic [7:0]  h_be8;
    logic [63:0] h_d64;
    logic        h_split, hit;
    logic        unused_ld_lsbs;

    function automatic logic [3:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic is_split(input logic [1:0] o, input logic [1:0] sz);
        logic [7:0] be8;
        be8 = {4'b0000, size_mask(sz)} << o;
        return |be8[7:4];
    endfunction

    assign push = WB_V_DCACHE_WRITE && (count_q != 3'd4);
    assign drop = WB_V_DCACHE_WRITE && (count_q == 3'd4);

    // Lane-align the head entry; the hi half spills into the next dword.
    assign h_addr  = addr_q[head_q];
    assign h_data  = data_q[head_q];
    assign h_size  = size_q[head_q];
    assign h_base  = {h_addr[31:2], 2'b00};
    assign h_be8   = {4'b0000, size_mask(h_size)} << h_addr[1:0];
    assign h_d64   = {32'b0, h_data} << {h_addr[1:0], 3'b000};
    assign h_split = |h_be8[7:4];

    always_comb begin
        DC_WR_REQ  = (state_q != IDLE);
        DC_WR_ADDR = h_base;
        DC_WR_BE   = h_be8[3:0];
        DC_WR_DATA = h_d64[31:0];
        if (state_q == REQ_HI) begin
            DC_WR_ADDR = h_base + 32'd4;
            DC_WR_BE   = h_be8[7:4];
            DC_WR_DATA = h_d64[63:32];
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE:    if (count_q != 3'd0) state_d = REQ_LO;
            REQ_LO:  if (DC_WR_ACK) begin
                         if (h_split) state_d = REQ_HI;
                         else         pop = 1'b1;
                     end
            REQ_HI:  if (DC_WR_ACK) pop = 1'b1;
            default: state_d = IDLE;
        endcase
        count_d = count_q + {2'b00, push} - {2'b00, pop};
        // Streaming: go straight to the next entry when one remains.
        if (pop) state_d = (count_d != 3'd0) ? REQ_LO : IDLE;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            head_q  <= 2'd0;
            tail_q  <= 2'd0;
            count_q <= 3'd0;
            valid_q <= 4'b0000;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (push) begin
                tail_q          <= tail_q + 2'd1;
                valid_q[tail_q] <= 1'b1;
            end
            if (pop) begin
                head_q          <= head_q + 2'd1;
                valid_q[head_q] <= 1'b0;
            end
            if (drop) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            addr_q[tail_q] <= WB_DCACHE_ADDRESS;
            data_q[tail_q] <= WB_DCACHE_DATA;
            size_q[tail_q] <= WB_DATASIZE;
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (valid_q[i]) begin
                if (LD_ADDRESS[31:2] == addr_q[i][31:2]) hit = 1'b1;
                if (is_split(addr_q[i][1:0], size_q[i]) &&
                    (LD_ADDRESS[31:2] == addr_q[i][31:2] + 30'd1)) hit = 1'b1;
            end
        end
    end

    assign unused_ld_lsbs  = ^LD_ADDRESS[1:0];
    assign Out_ld_conflict = LD_V & hit;
    assign Out_full        = (count_q == 3'd4);
    assign Out_empty       = (count_q == 3'd0) && (state_q == IDLE);
    assign Out_overflow    = ovf_q;
endmodule

// File: doc/dcache_store_buffer.md
# dcache_store_buffer

Receives validated store writes from the writeback stage and drains them to the data cache write port. Stores are held in a 4-entry FIFO, so a busy dcache does not immediately stall writeback. Each store is split into aligned 32-bit byte-enabled transactions, with two transactions when the store crosses a dword boundary. Stored entries are also matched against an in-flight load address so the memory stage can hold loads that would read stale data.

## Interface
Parameters: none. Depth fixed at 4 entries.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; synchronous, active-low.
- WB_V_DCACHE_WRITE  in  1  validated store from writeback (WB_V already ANDed in).
- WB_DATASIZE  in  2  store size: 00 = 8b, 01 = 16b, 10 = 32b, 11 = treated as 32b.
- WB_DCACHE_DATA  in  32  store data, right-justified.
- WB_DCACHE_ADDRESS  in  32  byte address, any alignment.
- LD_V  in  1  a load is requesting a conflict check this cycle.
- LD_ADDRESS  in  32  load byte address.
- DC_WR_ACK  in  1  dcache accepts the current request this cycle.
- DC_WR_REQ  out  1  write request to the dcache.
- DC_WR_ADDR  out  32  dword-aligned address; bits [1:0] = 00.
- DC_WR_DATA  out  32  lane-aligned write data.
- DC_WR_BE  out  4  byte enables.
- Out_full  out  1  count == 4; writeback must stall.
- Out_empty  out  1  count == 0 and FSM in IDLE.
- Out_ld_conflict  out  1  LD_V and the load dword overlaps a stored entry.
- Out_overflow  out  1  sticky: a push was dropped while the buffer was full.

## Operation
Entry contents:
- {addr[31:0], data[31:0], size[1:0]} plus a valid bit.
- Head and tail pointers are 2 bits and wrap 3 -> 0.
- Count is 3 bits, range 0..4.

Push:
- A push occurs when WB_V_DCACHE_WRITE = 1 and registered count < 4. It writes the tail entry and increments tail.
- If WB_V_DCACHE_WRITE = 1 while count == 4, the store is dropped, Out_overflow is set to 1, and it stays 1 until reset.

Lane alignment of the head entry:
- nbytes = 1, 2 or 4 from size.
- Lane offset o = addr[1:0].
- be8 = ((1 << nbytes) - 1) << o, 8 bits wide.
- d64 = {32'b0, data} << (8*o).
- Lo transaction: addr & ~3, be8[3:0], d64[31:0].
- Hi transaction: (addr & ~3) + 4, be8[7:4], d64[63:32]. The address add wraps modulo 2^32.
- The entry is split when be8[7:4] != 0.

Drain FSM:
- IDLE: if count > 0, go to REQ_LO.
- REQ_LO: DC_WR_REQ = 1 with the lo transaction.
  - On ACK, if split go to REQ_HI.
  - On ACK, if not split, pop the entry: head++, count--. Then go to REQ_LO if count after pop > 0, else IDLE.
- REQ_HI: DC_WR_REQ = 1 with the hi transaction. On ACK, pop and follow the same next-state rule.
- DC_WR_ACK is ignored when DC_WR_REQ = 0.

Request rules:
- DC_WR_ADDR, DC_WR_DATA and DC_WR_BE stay stable while DC_WR_REQ = 1 and ACK = 0.
- DC_WR_ADDR, DC_WR_DATA and DC_WR_BE are don't-care while DC_WR_REQ = 0.

Simultaneous push and pop:
- Count is unchanged.
- The push is accepted only if registered count < 4. A pop in the same cycle does not free a slot for a push while full.

Load conflict (combinational, registered entries only; the same-cycle push is excluded):
- An entry matches when LD_ADDRESS[31:2] equals the entry's lo dword index.
- A split entry also matches when LD_ADDRESS[31:2] equals its hi dword index.
- Out_ld_conflict is the OR of matches over valid entries, ANDed with LD_V.

Reset (RST = 0 at a clock edge):
- head = tail = count = 0, all valid bits cleared, FSM = IDLE.
- Outputs after that edge: DC_WR_REQ = 0, Out_overflow = 0, Out_full = 0, Out_empty = 1.
- Reset mid-transaction abandons the request with no further DC_WR_REQ. An ACK arriving in the reset cycle is ignored.

## Timing
- Push-to-request latency: an entry pushed into an empty buffer at edge N produces FSM = REQ_LO and DC_WR_REQ = 1 after edge N+1.
- With ACK held high, a non-split entry costs 1 cycle in REQ and a split entry costs 2.
- Back-to-back entries stream with no idle cycle between them.
- Out_full, Out_empty and Out_overflow are functions of registered state only.
- Out_ld_conflict is combinational from LD_V, LD_ADDRESS and registered entries.

## Test plan
- Aligned dword: push addr 0x1000, data 0xDEADBEEF, size 10, ACK tied high -> one request: ADDR 0x1000, BE 1111, DATA 0xDEADBEEF; Out_empty returns to 1.
- Byte and half lanes: byte at 0x2003, data 0x000000AB -> BE 1000, DATA 0xAB000000. Half at 0x2001, data 0x1234 -> BE 0110, DATA 0x00123400.
- Split store: dword at 0x3002, data 0x11223344 -> first request ADDR 0x3000, BE 1100, DATA 0x33440000; then ADDR 0x3004, BE 0011, DATA 0x00001122. The hi-dword load check also covers a dword at 0xFFFFFFFE, whose hi request goes to 0x00000000.
- Full and overflow: ACK held 0, push 5 stores -> Out_full = 1 after the 4th push; the 5th is dropped and Out_overflow = 1. Release ACK -> exactly 4 requests, issued in FIFO order.
- Load conflict: buffer holds a split store at 0x3002 -> LD_ADDRESS 0x3005 with LD_V = 1 gives Out_ld_conflict = 1; 0x3008 gives 0; LD_V = 0 gives 0.
- Reset mid-request: assert RST low while in REQ_HI with ACK = 0 -> after the edge DC_WR_REQ = 0, Out_empty = 1, and no request until a new push.
